io_input_debounce_reg: RTL and testbench
========================================

Name: io_input_debounce_reg

Overview:
- Memory-mapped input peripheral for the single-cycle computer; the read-side counterpart of the output port register.
- Synchronizes and debounces board slide switches and push keys.
- Latches key-press events into sticky, clear-on-read flags and counts presses.
- Presents a 32-bit read word to the CPU data path, selected by addr[7:2].

Parameters:
- SW_W, 8, number of slide-switch inputs.
- KEY_W, 4, number of push-key inputs.
- DEB_TICK, 50000, io_clk cycles between debounce samples (minimum 2).
- KEY_ACTIVE_LOW, 1, when 1 the raw keys are inverted so that pressed reads as 1.

Ports:
- io_clk  input  1  peripheral clock, rising edge.
- clrn  input  1  asynchronous, active-low reset.
- addr  input  32  CPU byte address; only addr[7:2] is decoded.
- read_io_enable  input  1  CPU read strobe for the IO space.
- sw_in  input  SW_W  raw slide switches, asynchronous.
- key_in  input  KEY_W  raw push keys, asynchronous.
- dataout  output  32  read data.
- irq  output  1  event interrupt; present only with IO_IRQ_EN.

Behaviour:
- Reset is clrn, asynchronous, active-low; the clock is io_clk.
- On reset, all of the following clear to 0:
  - synchronizer flops and sample registers
  - tick counter
  - debounced values
  - event flags
  - press counter
  - irq
- Synchronizer: every raw bit passes through 2 flops. The key polarity is applied after synchronization.
- Tick counter:
  - counts 0..DEB_TICK-1 and wraps.
  - tick pulses for 1 cycle when the count equals DEB_TICK-1.
- Debounce, per bit:
  - On tick, the synchronized bit is loaded into sample.
  - The debounced bit takes the sampled value on a tick only when the new sample equals the previous sample.
  - Result: it changes after 2 consecutive agreeing samples.
  - Latency from a stable input change to the debounced output is between DEB_TICK+2 and 2*DEB_TICK+2 cycles.
- Press event: a 0->1 transition of debounced key[i] sets evt[i] in the same cycle the debounced bit changes. Release produces no event.
- Press counter:
  - 8 bits, increments by the number of keys pressing in that cycle.
  - Saturates at 255; no wrap.
- Read map, decoded on addr[7:2] (unlisted codes return 0):
  - 6'b100000 (0x80): {zero, debounced sw}
  - 6'b100001 (0x84): {zero, debounced key}
  - 6'b100010 (0x88): {zero, evt}
  - 6'b100011 (0x8C): {zero, press counter}
- dataout is combinational from addr and the registered state. It is valid regardless of read_io_enable.
- Clear-on-read: at the io_clk edge where read_io_enable=1 and the address is 0x88, evt clears. At 0x8C, the counter clears.
  - The CPU sees the pre-clear value during the read cycle.
- Simultaneous set and clear:
  - A new event on bit i in the clearing cycle leaves evt[i]=1; other bits clear.
  - A counter clear coinciding with n new presses loads n.
- Reads at 0x80 and 0x84 have no side effects.
- Reset mid-debounce discards partial samples. After release, the debounced value re-acquires from 0, and a key held through reset generates one event.

Optional Feature:
- Macro: IO_IRQ_EN.
- Defined:
  - The irq output exists.
  - irq is a registered OR of evt, so it rises 1 cycle after any flag sets.
  - irq falls 1 cycle after a read at 0x88 empties evt.
  - Reset value is 0.
- Undefined: no irq port and no irq logic; all other behaviour is identical.

Test Plan (DEB_TICK=4 for simulation):
- Reset with sw_in=8'hA5 held -> dataout at 0x80 is 0 during reset; it reads 32'h000000A5 within 2*4+2=10 cycles after clrn rises, and not before 4+2=6 cycles.
- Glitch: sw_in[0] pulses 1 for 3 cycles between ticks -> debounced sw_in[0] never changes and 0x80 stays unchanged.
- key_in[2] driven low (pressed) and held 20 cycles -> 0x84 reads 32'h4, 0x88 reads 32'h4, 0x8C reads 1. Releasing the key produces no new event.
- Read 0x88 with read_io_enable=1 -> dataout=32'h4 that cycle and 0 afterward. Repeat with key_in[0] becoming debounced-pressed on the same edge -> afterward evt=32'h1.
- Press keys 260 times total -> 0x8C saturates at 32'hFF. Read-clear with 2 simultaneous presses on that edge -> reads 2 afterward.
- With IO_IRQ_EN: a single press -> irq=1 one cycle after evt sets. Read 0x88 -> irq=0 one cycle after the clear. Reads at 0x80 and 0x84 leave irq and evt unchanged.

Source files
------------

// File: rtl/io_input_debounce_reg.sv
// io_input_debounce_reg
// Read-side IO peripheral: synchronizes and debounces slide switches and
// push keys, latches key presses into sticky clear-on-read flags, counts
// presses (saturating), and returns a 32-bit word selected by addr[7:2].
//
// Read map (addr[7:2]):
//   0x80  debounced switches
//   0x84  debounced keys (pressed = 1)
//   0x88  press event flags, cleared by a read strobe
//   0x8C  press counter, cleared by a read strobe
//
// Optional build macro IO_IRQ_EN adds the irq output: a registered OR of
// the event flags.

module io_input_debounce_reg #(
    parameter int SW_W           = 8,
    parameter int KEY_W          = 4,
    parameter int DEB_TICK       = 50000,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic             io_clk,
    input  logic             clrn,
    input  logic [31:0]      addr,
    input  logic             read_io_enable,
    input  logic [SW_W-1:0]  sw_in,
    input  logic [KEY_W-1:0] key_in,
    output logic [31:0]      dataout
`ifdef IO_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int             TW        = $clog2(DEB_TICK);
    localparam logic [TW-1:0]  TICK_LAST = TW'(DEB_TICK - 1);
    localparam logic [5:0]     RD_SW     = 6'b100000;
    localparam logic [5:0]     RD_KEY    = 6'b100001;
    localparam logic [5:0]     RD_EVT    = 6'b100010;
    localparam logic [5:0]     RD_CNT    = 6'b100011;

    logic [SW_W-1:0]  sw_meta, sw_sync, sw_smp, deb_sw;
    logic [KEY_W-1:0] key_meta, key_sync, key_smp, deb_key;
    logic [KEY_W-1:0] key_pol, key_agree, deb_key_nxt, press, evt;
    logic [SW_W-1:0]  sw_agree;
    logic [TW-1:0]    tick_cnt;
    logic             tick;
    logic             evt_clr, cnt_clr;
    logic [7:0]       press_cnt, cnt_base, cnt_nxt;
    logic [8:0]       press_n;
    logic [9:0]       cnt_sum;
    logic             unused_addr;

    // Only addr[7:2] takes part in the decode.
    assign unused_addr = ^{addr[31:8], addr[1:0]};

    // Polarity is applied after the synchronizer so the flops see raw levels.
    assign key_pol = (KEY_ACTIVE_LOW != 0) ? ~key_sync : key_sync;
    assign tick    = (tick_cnt == TICK_LAST);

    // Two-flop synchronizers for every raw input bit.
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_meta <= '0;
            key_sync <= '0;
        end else begin
            sw_meta  <= sw_in;
            sw_sync  <= sw_meta;
            key_meta <= key_in;
            key_sync <= key_meta;
        end
    end

    // Sample-interval counter, 0..DEB_TICK-1, wrapping on tick.
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // A bit is accepted only when the new sample matches the previous one.
    assign sw_agree    = ~(sw_sync ^ sw_smp);
    assign key_agree   = ~(key_pol ^ key_smp);
    assign deb_key_nxt = tick ? ((key_agree & key_pol) | (~key_agree & deb_key)) : deb_key;
    assign press       = deb_key_nxt & ~deb_key;

    // Sample registers and debounced values, updated on tick only.
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            sw_smp  <= '0;
            key_smp <= '0;
            deb_sw  <= '0;
            deb_key <= '0;
        end else begin
            if (tick) begin
                sw_smp  <= sw_sync;
                key_smp <= key_pol;
                deb_sw  <= (sw_agree & sw_sync) | (~sw_agree & deb_sw);
            end
            deb_key <= deb_key_nxt;
        end
    end

    assign evt_clr = read_io_enable && (addr[7:2] == RD_EVT);
    assign cnt_clr = read_io_enable && (addr[7:2] == RD_CNT);

    // Number of keys whose debounced value rises this cycle, and the
    // saturating counter update (a clear still keeps this cycle's presses).
    always_comb begin
        press_n = '0;
        for (int i = 0; i < KEY_W; i++) begin
            press_n = press_n + 9'(press[i]);
        end
        cnt_base = cnt_clr ? 8'd0 : press_cnt;
        cnt_sum  = {2'b00, cnt_base} + {1'b0, press_n};
        cnt_nxt  = (cnt_sum > 10'd255) ? 8'hFF : cnt_sum[7:0];
    end

    // Sticky event flags and press counter; a new press beats the clear.
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            evt       <= '0;
            press_cnt <= '0;
        end else begin
            evt       <= (evt_clr ? '0 : evt) | press;
            press_cnt <= cnt_nxt;
        end
    end

    // Read mux; the CPU sees the pre-clear value during a clearing read.
    always_comb begin
        dataout = 32'h0;
        case (addr[7:2])
            RD_SW:   dataout = 32'(deb_sw);
            RD_KEY:  dataout = 32'(deb_key);
            RD_EVT:  dataout = 32'(evt);
            RD_CNT:  dataout = 32'(press_cnt);
            default: dataout = 32'h0;
        endcase
    end

`ifdef IO_IRQ_EN
    // Interrupt follows the flags one cycle late.
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            irq <= 1'b0;
        end else begin
            irq <= |evt;
        end
    end
`endif

endmodule

// File: tb/tb_io_input_debounce_reg.sv
// Testbench for io_input_debounce_reg with DEB_TICK=4.
// Stimulus pushes expected read values into a scoreboard queue; the monitor
// compares them against the DUT on the falling clock edge.
// Build with IO_IRQ_EN defined to also cover the irq output.

module tb_io_input_debounce_reg;

    logic        io_clk = 1'b0;
    logic        clrn;
    logic [31:0] addr;
    logic        read_io_enable;
    logic [7:0]  sw_in;
    logic [3:0]  key_in;
    logic [31:0] dataout;
`ifdef IO_IRQ_EN
    logic        irq;
`endif

    typedef struct {
        bit          is_irq;
        logic [31:0] exp;
        string       tag;
    } sb_t;

    sb_t         sb[$];
    sb_t         cur;
    logic [31:0] act;
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;

    io_input_debounce_reg #(
        .SW_W(8), .KEY_W(4), .DEB_TICK(4), .KEY_ACTIVE_LOW(1)
    ) dut (
        .io_clk(io_clk),
        .clrn(clrn),
        .addr(addr),
        .read_io_enable(read_io_enable),
        .sw_in(sw_in),
        .key_in(key_in),
        .dataout(dataout)
`ifdef IO_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 io_clk = ~io_clk;

    // Edges since reset release; debounce ticks land on edges with cyc%4==0.
    always @(posedge io_clk) cyc <= clrn ? cyc + 1 : 0;

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge io_clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            act = dataout;
`ifdef IO_IRQ_EN
            if (cur.is_irq) act = {31'b0, irq};
`endif
            n_vec++;
            if (act !== cur.exp) begin
                n_bad++;
                $display("FAIL %s: got %h, expected %h", cur.tag, act, cur.exp);
            end
        end
    end

    task automatic step();
        @(posedge io_clk);
        #1;
    endtask

    task automatic expect_data(input logic [31:0] a, input logic [31:0] e, input string t);
        sb_t x;
        addr     = a;
        x.is_irq = 1'b0;
        x.exp    = e;
        x.tag    = t;
        sb.push_back(x);
    endtask

`ifdef IO_IRQ_EN
    task automatic expect_irq(input logic e, input string t);
        sb_t x;
        x.is_irq = 1'b1;
        x.exp    = {31'b0, e};
        x.tag    = t;
        sb.push_back(x);
    endtask
`endif

    task automatic chk(input logic [31:0] a, input logic [31:0] e, input string t);
        expect_data(a, e, t);
        step();
    endtask

    // Advance to just after a tick edge.
    task automatic wait_phase();
        for (int i = 0; i < 4 && (cyc % 4) != 0; i++) step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn           = 1'b0;
        sw_in          = 8'hA5;
        key_in         = 4'hF;
        addr           = 32'h0;
        read_io_enable = 1'b0;
        step();
        chk(32'h80, 32'h0, "rst_sw");
        chk(32'h88, 32'h0, "rst_evt");
        chk(32'h8C, 32'h0, "rst_cnt");
        addr = 32'h80;
        clrn = 1'b1;

        // Acquisition window after reset release.
        for (int k = 0; k <= 12; k++) begin
            if (k < 6)        chk(32'h80, 32'h0,  "acq_early");
            else if (k >= 10) chk(32'h80, 32'hA5, "acq_sw");
            else              step();
        end
        addr = 32'h80;
        #1;
        n_vec++;
        if (dataout !== 32'hA5) begin
            n_bad++;
            $display("FAIL acq_direct: got %h, expected %h", dataout, 32'hA5);
        end

        // Switch change then a 3-cycle glitch between ticks.
        sw_in = 8'hA4;
        repeat (12) step();
        chk(32'h80, 32'hA4, "sw_a4");
        wait_phase();
        step(); step();
        sw_in = 8'hA5;
        repeat (3) step();
        sw_in = 8'hA4;
        for (int k = 0; k < 12; k++) chk(32'h80, 32'hA4, "glitch");

        // Key 2 press and release.
        key_in = 4'b1011;
        repeat (20) step();
        addr = 32'h84;
        #1;
        n_vec++;
        if (dataout !== 32'h4) begin
            n_bad++;
            $display("FAIL key2_direct: got %h, expected %h", dataout, 32'h4);
        end
        chk(32'h84, 32'h4, "key2_deb");
        chk(32'h88, 32'h4, "key2_evt");
        chk(32'h8C, 32'h1, "key2_cnt");
        key_in = 4'hF;
        repeat (12) step();
        chk(32'h84, 32'h0, "key2_rel");
        chk(32'h88, 32'h4, "no_rel_evt");
        chk(32'h8C, 32'h1, "no_rel_cnt");

        // Clear-on-read of evt.
        read_io_enable = 1'b1;
        chk(32'h88, 32'h4, "rc_evt_pre");
        read_io_enable = 1'b0;
        chk(32'h88, 32'h0, "rc_evt_post");
        chk(32'h8C, 32'h1, "rc_evt_cnt");

        // Clear coinciding with key 0 becoming debounced-pressed.
        key_in = 4'b1011;
        repeat (20) step();
        chk(32'h88, 32'h4, "key2_evt2");
        wait_phase();
        key_in = 4'b1010;
        repeat (7) step();
        read_io_enable = 1'b1;
        chk(32'h88, 32'h4, "rc_coll_pre");
        read_io_enable = 1'b0;
        chk(32'h88, 32'h1, "rc_coll_post");
        chk(32'h8C, 32'h3, "rc_coll_cnt");
        chk(32'h84, 32'h5, "rc_coll_deb");
        key_in = 4'hF;
        repeat (12) step();

`ifdef IO_IRQ_EN
        expect_irq(1'b1, "irq_held");
        read_io_enable = 1'b1;
        expect_data(32'h88, 32'h1, "irq_rd_pre");
        step();
        read_io_enable = 1'b0;
        expect_data(32'h88, 32'h0, "irq_rd_post");
        expect_irq(1'b1, "irq_lag");
        step();
        expect_irq(1'b0, "irq_fall");
        step();
        wait_phase();
        key_in = 4'b1101;
        repeat (7) step();
        expect_data(32'h88, 32'h0, "irq_pre_evt");
        expect_irq(1'b0, "irq_pre_low");
        step();
        expect_data(32'h88, 32'h2, "irq_evt_set");
        expect_irq(1'b0, "irq_not_yet");
        step();
        expect_irq(1'b1, "irq_rise");
        read_io_enable = 1'b1;
        expect_data(32'h80, 32'hA4, "irq_rd80");
        step();
        expect_data(32'h84, 32'h2, "irq_rd84");
        expect_irq(1'b1, "irq_keep80");
        step();
        read_io_enable = 1'b0;
        expect_data(32'h88, 32'h2, "irq_evt_kept");
        expect_irq(1'b1, "irq_keep84");
        step();
        key_in = 4'hF;
        repeat (12) step();
        read_io_enable = 1'b1;
        chk(32'h88, 32'h2, "irq_clr_pre");
        read_io_enable = 1'b0;
        chk(32'h88, 32'h0, "irq_clr_post");
`else
        read_io_enable = 1'b1;
        chk(32'h88, 32'h1, "evt_clr_pre");
        read_io_enable = 1'b0;
        chk(32'h88, 32'h0, "evt_clr_post");
`endif

        // 260 presses (65 rounds of all four keys) saturate the counter.
        for (int r = 0; r < 65; r++) begin
            key_in = 4'h0;
            repeat (12) step();
            key_in = 4'hF;
            repeat (12) step();
        end
        addr = 32'h8C;
        #1;
        n_vec++;
        if (dataout !== 32'hFF) begin
            n_bad++;
            $display("FAIL sat_direct: got %h, expected %h", dataout, 32'hFF);
        end
        chk(32'h8C, 32'hFF, "sat_cnt");
        chk(32'h88, 32'hF,  "sat_evt");

        // Counter clear coinciding with two presses loads 2.
        wait_phase();
        key_in = 4'b0101;
        repeat (7) step();
        read_io_enable = 1'b1;
        chk(32'h8C, 32'hFF, "rc_cnt_pre");
        read_io_enable = 1'b0;
        chk(32'h8C, 32'h2, "rc_cnt_load");
        chk(32'h88, 32'hF, "rc_cnt_evt");

        repeat (2) step();
        addr = 32'h8C;
        #1;
        n_vec++;
        if (dataout !== 32'h2) begin
            n_bad++;
            $display("FAIL cnt_direct: got %h, expected %h", dataout, 32'h2);
        end
        addr = 32'h88;
        #1;
        n_vec++;
        if (dataout !== 32'hF) begin
            n_bad++;
            $display("FAIL evt_direct: got %h, expected %h", dataout, 32'hF);
        end
        if (n_bad != 0) $display("FAIL summary: got %0d miscompares, expected 0", n_bad);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
